// File: rtl/count_gate_pkg.sv
// Shared types and constants for the counter gate/capture controller.
package count_gate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    localparam int CNT_W_DEF = 32;
    localparam int SEQ_W     = 16;
    localparam int TMR_W     = 32;

    // A zero gate length still opens the gate for one cycle.
    function automatic logic [TMR_W-1:0] gate_len_norm(input logic [TMR_W-1:0] len);
        return (len == '0) ? TMR_W'(1) : len;
    endfunction

endpackage

// File: rtl/count_gate_ctrl_gate_timer.sv
// Loadable 32-bit down counter timing the CLEAR, GATE and SETTLE phases.
module gate_timer
    import count_gate_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             en,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - TMR_W'(1);
        end
    end

    // A phase loaded with N ends on its Nth cycle, so no wrap is ever needed.
    assign done = (count == TMR_W'(1));

endmodule

// File: rtl/count_gate_ctrl.sv
// Gate/capture controller for the multichannel pulse counters.
// Optional build macro GATE_SEQ_EN adds the seq_o capture sequence number.
module count_gate_ctrl
    import count_gate_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  cont_i,
    input  logic                  abort_i,
    input  logic [31:0]           gate_len_i,
    input  logic [N_CH*CNT_W-1:0] cnt_i,
    output logic                  cnt_ena_o,
    output logic                  cnt_rst_no,
    output logic [N_CH*CNT_W-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ack_i,
    output logic                  busy_o
`ifdef GATE_SEQ_EN
    ,
    output logic [SEQ_W-1:0]      seq_o
`endif
);

    localparam logic [TMR_W-1:0] CLR_LOAD    = TMR_W'(CLR_CYCLES);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES);

    state_t           state;
    logic [TMR_W-1:0] gate_len_q;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    gate_timer u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (tmr_load),
        .en       (1'b1),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Timer is reloaded on the edge that enters each timed phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LOAD;
                end
            end
            CLEAR: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = gate_len_q;
                end
            end
            GATE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end
            end
            HOLD: begin
                if (ack_i && cont_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LOAD;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            gate_len_q <= '0;
            cnt_ena_o  <= 1'b0;
            cnt_rst_no <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
`ifdef GATE_SEQ_EN
            seq_o      <= '0;
`endif
        end else if (abort_i) begin
            // data_o and seq_o keep the last completed capture.
            state      <= IDLE;
            cnt_ena_o  <= 1'b0;
            cnt_rst_no <= 1'b1;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_rst_no <= 1'b1;
                    if (start_i) begin
                        state      <= CLEAR;
                        gate_len_q <= gate_len_norm(gate_len_i);
                        cnt_rst_no <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (tmr_done) begin
                        state      <= GATE;
                        cnt_rst_no <= 1'b1;
                        cnt_ena_o  <= 1'b1;
                    end
                end
                GATE: begin
                    if (tmr_done) begin
                        state     <= SETTLE;
                        cnt_ena_o <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (tmr_done) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state   <= HOLD;
                    data_o  <= cnt_i;
                    valid_o <= 1'b1;
`ifdef GATE_SEQ_EN
                    seq_o   <= seq_o + SEQ_W'(1);
`endif
                end
                HOLD: begin
                    if (ack_i) begin
                        valid_o <= 1'b0;
                        if (cont_i) begin
                            state      <= CLEAR;
                            gate_len_q <= gate_len_norm(gate_len_i);
                            cnt_rst_no <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_gate_ctrl.sv
// Directed bench for count_gate_ctrl with a two-channel pulse counter model.
// Build with GATE_SEQ_EN defined to also check seq_o.
module tb_count_gate_ctrl;

    localparam int N_CH  = 2;
    localparam int CNT_W = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  cont = 1'b0;
    logic                  abort = 1'b0;
    logic                  ack = 1'b0;
    logic [31:0]           gate_len = '0;
    logic [N_CH*CNT_W-1:0] cnt;
    logic [N_CH*CNT_W-1:0] data;
    logic                  ena, rst_n, valid, busy;
`ifdef GATE_SEQ_EN
    logic [15:0]           seq;
`endif

    int total = 0;
    int bad   = 0;
    int exp_seq = 0;
    int ena_cnt = 0, rstlo_cnt = 0, valid_cnt = 0;
    int base_e = 0, base_r = 0, base_v = 0;

    always #5 clk = ~clk;

    count_gate_ctrl #(
        .N_CH          (N_CH),
        .CNT_W         (CNT_W),
        .CLR_CYCLES    (2),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .cont_i     (cont),
        .abort_i    (abort),
        .gate_len_i (gate_len),
        .cnt_i      (cnt),
        .cnt_ena_o  (ena),
        .cnt_rst_no (rst_n),
        .data_o     (data),
        .valid_o    (valid),
        .ack_i      (ack),
        .busy_o     (busy)
`ifdef GATE_SEQ_EN
        ,
        .seq_o      (seq)
`endif
    );

    // Counter model: ch0 sees one pulse every second clock, ch1 one pulse per clock.
    logic [31:0] c0 = '0, c1 = '0;
    logic        ph = 1'b0;
    assign cnt = {c1, c0};

    always @(posedge clk) begin
        if (!rst_n) begin
            c0 <= '0;
            c1 <= '0;
            ph <= 1'b0;
        end else begin
            ph <= ~ph;
            if (ena) begin
                if (ph) c0 <= c0 + 1;
                c1 <= c1 + 1;
            end
        end
    end

    // Free-running edge monitors; tests compare differences against snapshots.
    always @(posedge clk) begin
        ena_cnt   <= ena_cnt + (ena ? 1 : 0);
        rstlo_cnt <= rstlo_cnt + (rst_n ? 0 : 1);
        valid_cnt <= valid_cnt + (valid ? 1 : 0);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        base_e = ena_cnt;
        base_r = rstlo_cnt;
        base_v = valid_cnt;
    endtask

    task automatic chk_seq();
`ifdef GATE_SEQ_EN
        chk("seq", 64'(seq), 64'(exp_seq));
`endif
    endtask

    // Called right after the edge that launched a measurement (start or cont re-arm).
    task automatic run_meas(input int g, input logic [63:0] exp_data);
        ticks(g + 6);
        chk("valid_early", 64'(valid), 64'd0);
        tick();
        chk("valid_rise", 64'(valid), 64'd1);
        chk("data", data, exp_data);
        chk("gate_cycles", 64'(ena_cnt - base_e), 64'(g));
        chk("clear_cycles", 64'(rstlo_cnt - base_r), 64'd2);
        exp_seq++;
        chk_seq();
    endtask

    initial begin
        // Reset state, applied asynchronously before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_ena", 64'(ena), 64'd0);
        chk("rst_rstn", 64'(rst_n), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", data, 64'd0);
        chk_seq();
        ticks(2);
        rst = 1'b0;
        #1 chk("rstn_before_edge", 64'(rst_n), 64'd0);
        tick();
        chk("rstn_idle", 64'(rst_n), 64'd1);

        // Single shot, gate 10
        snap();
        gate_len = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_clear", 64'(rst_n), 64'd0);
        run_meas(10, {32'd10, 32'd5});
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t1_ack_valid", 64'(valid), 64'd0);
        chk("t1_ack_busy", 64'(busy), 64'd0);

        // Zero gate length behaves as one cycle
        snap();
        gate_len = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_meas(1, {32'd1, 32'd0});
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Continuous mode, three rounds; gate_len_i changes mid-round are ignored
        cont = 1'b1;
        snap();
        gate_len = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        gate_len = 32'd99;
        run_meas(4, {32'd4, 32'd2});
        ticks(3);
        chk("t3_hold1", 64'(valid), 64'd1);
        snap();
        gate_len = 32'd6;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        gate_len = 32'd99;
        chk("t3_rearm_valid", 64'(valid), 64'd0);
        chk("t3_rearm_busy", 64'(busy), 64'd1);
        run_meas(6, {32'd6, 32'd3});
        ticks(3);
        snap();
        gate_len = 32'd2;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        run_meas(2, {32'd2, 32'd1});
        ticks(3);
        cont = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t3_end_valid", 64'(valid), 64'd0);
        chk("t3_end_busy", 64'(busy), 64'd0);

        // Abort in the fifth gate cycle of ten
        snap();
        gate_len = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(6);
        chk("t4_in_gate", 64'(ena), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_ena", 64'(ena), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_valid", 64'(valid), 64'd0);
        chk("t4_rstn", 64'(rst_n), 64'd1);
        chk("t4_data_kept", data, {32'd2, 32'd1});
        chk_seq();
        ticks(30);
        chk("t4_no_result", 64'(valid_cnt - base_v), 64'd0);
        chk("t4_gate_cycles", 64'(ena_cnt - base_e), 64'd5);

        // Asynchronous reset during SETTLE
        gate_len = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(5);
        chk("t5_settle_ena", 64'(ena), 64'd0);
        chk("t5_settle_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_rstn", 64'(rst_n), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_data", data, 64'd0);
        chk("t5_rst_valid", 64'(valid), 64'd0);
        exp_seq = 0;
        chk_seq();
        tick();
        rst = 1'b0;
        #1 chk("t5_rstn_held", 64'(rst_n), 64'd0);
        tick();
        chk("t5_rstn_rel", 64'(rst_n), 64'd1);
        snap();
        ticks(20);
        chk("t5_no_result", 64'(valid_cnt - base_v), 64'd0);

        // ack held high from IDLE, extra start during GATE: one result only
        snap();
        ack = 1'b1;
        gate_len = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(7);
        chk("t6_valid_early", 64'(valid), 64'd0);
        tick();
        chk("t6_valid", 64'(valid), 64'd1);
        chk("t6_data", data, {32'd4, 32'd2});
        exp_seq++;
        chk_seq();
        tick();
        chk("t6_acked", 64'(valid), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        ticks(20);
        chk("t6_single", 64'(valid_cnt - base_v), 64'd1);
        chk("t6_gate_cycles", 64'(ena_cnt - base_e), 64'd4);
        chk("t6_still_idle", 64'(busy), 64'd0);
        ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
